// File: rtl/fsm_alarm_pkg.sv
// fsm_alarm_pkg
// Shared definitions for the error-alarm block that sits behind the
// sequence-lock FSM: state encodings, the state enum built on them, and
// default values for the top-level parameters.
// The optional blinking alarm is enabled by defining ALARM_BLINK_EN.

package fsm_alarm_pkg;

    // Raw 2-bit state encodings, kept as named constants so other blocks
    // (or a debug probe) can decode the state register without the enum.
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ARMED   = 2'd1;
    localparam logic [1:0] ST_LOCKED  = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    // Moore state machine states, pinned to the encodings above.
    typedef enum logic [1:0] {
        S_IDLE    = ST_IDLE,
        S_ARMED   = ST_ARMED,
        S_LOCKED  = ST_LOCKED,
        S_RELEASE = ST_RELEASE
    } state_t;

    // Default tuning: three errors inside a 16-clock inactivity window
    // lock the upstream entry for 64 clocks.
    localparam int DEF_MAX_ERR     = 3;
    localparam int DEF_WINDOW      = 16;
    localparam int DEF_LOCK_CYCLES = 64;
    localparam int DEF_CNT_W       = 4;
    localparam int DEF_TMR_W       = 8;
    localparam int DEF_BLINK_HALF  = 4;

endpackage

// File: rtl/fsm_alarm_rise_det.sv
// rise_det
// Registered rising-edge detector. The input is captured every clock and
// the pulse is the combination "high now, low last clock", so a level
// that is already high when reset releases produces a pulse on the very
// first clock. The register clears to 0 under the active-low async reset.

module rise_det (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic pulse
);

    logic d_q;

    // Remember last cycle's level of d for edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d;
        end
    end

    assign pulse = d & ~d_q;

endmodule

// File: rtl/fsm_alarm.sv
// fsm_alarm
// Error-rate alarm placed after the sequence-lock FSM. Each rising edge of
// err_in is one error event. Events are counted while they keep arriving
// within WINDOW clocks of each other; reaching MAX_ERR events locks the
// upstream a/b entry (lockout) for LOCK_CYCLES clocks, after which the
// block passes through a one-clock RELEASE state and returns to IDLE.
// Optional feature macro: ALARM_BLINK_EN -- when defined, alarm blinks
// with a half-period of BLINK_HALF clocks while locked; when undefined,
// alarm is simply a copy of lockout.

import fsm_alarm_pkg::*;

module fsm_alarm #(
    parameter int MAX_ERR     = DEF_MAX_ERR,
    parameter int WINDOW      = DEF_WINDOW,
    parameter int LOCK_CYCLES = DEF_LOCK_CYCLES,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int TMR_W       = DEF_TMR_W
`ifdef ALARM_BLINK_EN
    ,
    parameter int BLINK_HALF  = DEF_BLINK_HALF
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             err_in,
    input  logic             clr,
    output logic             lockout,
    output logic             alarm,
    output logic [CNT_W-1:0] err_cnt,
    output logic [TMR_W-1:0] lock_tmr
);

    // Reload values, sized once so the next-state logic stays width-clean.
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_ERR);
    localparam logic [TMR_W-1:0] WIN_INIT  = TMR_W'(WINDOW - 1);
    localparam logic [TMR_W-1:0] LOCK_INIT = TMR_W'(LOCK_CYCLES - 1);

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] cnt_n;
    logic [TMR_W-1:0] win_tmr;
    logic [TMR_W-1:0] win_n;
    logic [TMR_W-1:0] lock_n;
    logic             ev;

    // A held-high err_in is a single event; only a fresh rising edge counts.
    rise_det u_rise_det (
        .clk   (clk),
        .reset (reset),
        .d     (err_in),
        .pulse (ev)
    );

    // State register plus the event counter and the two down-counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            err_cnt  <= '0;
            win_tmr  <= '0;
            lock_tmr <= '0;
        end else begin
            state    <= state_n;
            err_cnt  <= cnt_n;
            win_tmr  <= win_n;
            lock_tmr <= lock_n;
        end
    end

    // Next-state and counter updates; clr beats a same-cycle event, and an
    // event beats window expiry so a late-arriving error is never lost.
    always_comb begin
        state_n = state;
        cnt_n   = err_cnt;
        win_n   = win_tmr;
        lock_n  = lock_tmr;

        if (clr) begin
            state_n = S_IDLE;
            cnt_n   = '0;
            win_n   = '0;
            lock_n  = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (ev) begin
                        cnt_n = CNT_ONE;
                        if (MAX_ERR == 1) begin
                            state_n = S_LOCKED;
                            lock_n  = LOCK_INIT;
                            win_n   = '0;
                        end else begin
                            state_n = S_ARMED;
                            win_n   = WIN_INIT;
                        end
                    end
                end

                S_ARMED: begin
                    if (ev) begin
                        if ((err_cnt + CNT_ONE) == CNT_MAX) begin
                            state_n = S_LOCKED;
                            cnt_n   = CNT_MAX;
                            lock_n  = LOCK_INIT;
                            win_n   = '0;
                        end else begin
                            cnt_n = err_cnt + CNT_ONE;
                            win_n = WIN_INIT;
                        end
                    end else if (win_tmr == '0) begin
                        state_n = S_IDLE;
                        cnt_n   = '0;
                    end else begin
                        win_n = win_tmr - 1'b1;
                    end
                end

                S_LOCKED: begin
                    if (lock_tmr == '0) begin
                        state_n = S_RELEASE;
                        cnt_n   = '0;
                    end else begin
                        lock_n = lock_tmr - 1'b1;
                    end
                end

                S_RELEASE: begin
                    state_n = S_IDLE;
                    cnt_n   = '0;
                    win_n   = '0;
                    lock_n  = '0;
                end

                default: begin
                    state_n = S_IDLE;
                    cnt_n   = '0;
                    win_n   = '0;
                    lock_n  = '0;
                end
            endcase
        end
    end

    // Lockout is a pure decode of the state register, so it cannot glitch
    // and falls immediately when the async reset clears the state.
    assign lockout = (state == S_LOCKED);

`ifdef ALARM_BLINK_EN

    localparam int BLK_W = $clog2(BLINK_HALF + 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_HALF - 1);

    logic [BLK_W-1:0] blink_cnt;
    logic             blink_off;

    // Blink phase counter: idle at zero outside LOCKED, so every lockout
    // starts with the alarm lit and toggles every BLINK_HALF clocks.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            blink_cnt <= '0;
            blink_off <= 1'b0;
        end else if (state != S_LOCKED) begin
            blink_cnt <= '0;
            blink_off <= 1'b0;
        end else if (blink_cnt == BLK_LAST) begin
            blink_cnt <= '0;
            blink_off <= ~blink_off;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    assign alarm = lockout & ~blink_off;

`else

    assign alarm = lockout;

`endif

endmodule
